// File: rtl/tour_cmd_seq.sv
// Knight's-tour playback sequencer: walks the solver's move list and turns each
// one-hot move into a vertical leg then a horizontal leg for the command processor.
module tour_cmd_seq #(
  parameter int          NUM_MOVES = 24,
  parameter logic [3:0]  OP_MOVE   = 4'h2,
  parameter logic [3:0]  OP_FANF   = 4'h3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_tour,
  input  logic [7:0]  i_move,
  output logic [4:0]  o_mv_indx,
  output logic [15:0] o_cmd,
  output logic        o_cmd_rdy,
  input  logic        i_clr_cmd_rdy,
  input  logic        i_send_resp,
  output logic        o_tour_done,
  output logic        o_tour_err
);

  // state    | meaning
  // S_IDLE   | waiting for start_tour
  // S_VERT   | check move, present vertical leg, wait for accept
  // S_WAIT_V | vertical leg accepted, waiting for mover response
  // S_HORZ   | present horizontal leg, wait for accept
  // S_WAIT_H | horizontal leg accepted, waiting for mover response
  typedef enum logic [2:0] {
    S_IDLE,
    S_VERT,
    S_WAIT_V,
    S_HORZ,
    S_WAIT_H
  } state_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  state_t      r_state;
  logic [4:0]  r_mv_indx;
  logic [15:0] r_cmd;
  logic [15:0] r_hcmd;
  logic        r_cmd_rdy;
  logic        r_tour_done;
  logic        r_tour_err;

  logic        w_onehot;
  logic [7:0]  w_hdg_v;
  logic [7:0]  w_hdg_h;
  logic [3:0]  w_sq_v;
  logic [3:0]  w_sq_h;
  logic [15:0] w_vcmd;
  logic [15:0] w_hcmd;

  // Anything outside the eight knight moves (zero or multi-bit) is not one-hot.
  always_comb begin
    w_onehot = 1'b0;
    w_hdg_v  = HDG_N;
    w_hdg_h  = HDG_E;
    w_sq_v   = 4'd0;
    w_sq_h   = 4'd0;
    case (i_move)
      8'h01: begin w_onehot = 1'b1; w_hdg_v = HDG_N; w_sq_v = 4'd2; w_hdg_h = HDG_W; w_sq_h = 4'd1; end
      8'h02: begin w_onehot = 1'b1; w_hdg_v = HDG_N; w_sq_v = 4'd2; w_hdg_h = HDG_E; w_sq_h = 4'd1; end
      8'h04: begin w_onehot = 1'b1; w_hdg_v = HDG_N; w_sq_v = 4'd1; w_hdg_h = HDG_W; w_sq_h = 4'd2; end
      8'h08: begin w_onehot = 1'b1; w_hdg_v = HDG_S; w_sq_v = 4'd1; w_hdg_h = HDG_W; w_sq_h = 4'd2; end
      8'h10: begin w_onehot = 1'b1; w_hdg_v = HDG_S; w_sq_v = 4'd2; w_hdg_h = HDG_W; w_sq_h = 4'd1; end
      8'h20: begin w_onehot = 1'b1; w_hdg_v = HDG_S; w_sq_v = 4'd2; w_hdg_h = HDG_E; w_sq_h = 4'd1; end
      8'h40: begin w_onehot = 1'b1; w_hdg_v = HDG_S; w_sq_v = 4'd1; w_hdg_h = HDG_E; w_sq_h = 4'd2; end
      8'h80: begin w_onehot = 1'b1; w_hdg_v = HDG_N; w_sq_v = 4'd1; w_hdg_h = HDG_E; w_sq_h = 4'd2; end
      default: w_onehot = 1'b0;
    endcase
    w_vcmd = {OP_MOVE, w_hdg_v, w_sq_v};
    w_hcmd = {OP_FANF, w_hdg_h, w_sq_h};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mv_indx   <= 5'd0;
      r_cmd       <= 16'h0000;
      r_hcmd      <= 16'h0000;
      r_cmd_rdy   <= 1'b0;
      r_tour_done <= 1'b0;
      r_tour_err  <= 1'b0;
    end else begin
      r_tour_done <= 1'b0;
      r_tour_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_tour) begin
            r_mv_indx <= 5'd0;
            r_state   <= S_VERT;
          end
        end
        S_VERT: begin
          // Horizontal leg is captured here so the move is decoded only once per index.
          if (!r_cmd_rdy) begin
            if (!w_onehot) begin
              r_tour_err <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_cmd     <= w_vcmd;
              r_hcmd    <= w_hcmd;
              r_cmd_rdy <= 1'b1;
            end
          end else if (i_clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= S_WAIT_V;
          end
        end
        S_WAIT_V: begin
          if (i_send_resp) r_state <= S_HORZ;
        end
        S_HORZ: begin
          if (!r_cmd_rdy) begin
            r_cmd     <= r_hcmd;
            r_cmd_rdy <= 1'b1;
          end else if (i_clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= S_WAIT_H;
          end
        end
        S_WAIT_H: begin
          if (i_send_resp) begin
            if (r_mv_indx == LAST_INDX) begin
              r_tour_done <= 1'b1;
              r_mv_indx   <= 5'd0;
              r_state     <= S_IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + 5'd1;
              r_state   <= S_VERT;
            end
          end
        end
        default: begin
          r_cmd_rdy <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mv_indx   = r_mv_indx;
  assign o_cmd       = r_cmd;
  assign o_cmd_rdy   = r_cmd_rdy;
  assign o_tour_done = r_tour_done;
  assign o_tour_err  = r_tour_err;

endmodule
